// File: rtl/rf_port_arbiter_if.sv
// Requester-side bundle for rf_port_arbiter: per-requester request bits, packed address/data
// buses and the one-hot accept/response pulses.
interface rf_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDRESS = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ*ADDRESS-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]   req_wdata;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [WIDTH-1:0]           rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rf_port_arbiter.sv
// Shares a single-port, 1-cycle-read register file between NUM_REQ requesters.
// Round-robin by default; define RF_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module rf_port_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDRESS = 4
) (
    input  logic               clk,
    input  logic               rst,
    rf_port_arbiter_if.slave   bus,
    output logic               busy,
    output logic               err,
    output logic               mem_wr_en,
    output logic               mem_rd_en,
    output logic [ADDRESS-1:0] mem_address,
    output logic [WIDTH-1:0]   mem_in_data,
    input  logic [WIDTH-1:0]   mem_out_data,
    input  logic               mem_valid_out
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

    state_e               state_q;
    logic [IdxW-1:0]      gnt_q;
    logic                 wr_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [WIDTH-1:0]     rsp_rdata_q;

    logic                 any_valid;
    logic                 accept;
    logic [IdxW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [NUM_REQ-1:0]   gnt_q_oh;

    assign any_valid = |bus.req_valid;
    // Granted bit is always a valid one, so ready&valid reduces to this.
    assign accept    = rst && (state_q == StIdle) && any_valid;

`ifdef RF_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) gnt_idx = IdxW'(i);
        end
    end
`else
    logic [IdxW-1:0] rr_ptr_q;

    // Scan from the far end so the nearest valid requester after rr_ptr wins.
    always_comb begin
        int idx;
        gnt_idx = '0;
        idx     = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
            if (bus.req_valid[idx]) gnt_idx = IdxW'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= IdxW'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr_q <= gnt_idx;
        end
    end
`endif

    always_comb begin
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = 1'b1;
        gnt_q_oh        = '0;
        gnt_q_oh[gnt_q] = 1'b1;
    end

    assign bus.req_ready = accept ? gnt_oh : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            wr_q        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_address <= '0;
            mem_in_data <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            err         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        gnt_q       <= gnt_idx;
                        wr_q        <= bus.req_write[gnt_idx];
                        mem_wr_en   <= bus.req_write[gnt_idx];
                        mem_rd_en   <= ~bus.req_write[gnt_idx];
                        mem_address <= bus.req_addr[gnt_idx*ADDRESS +: ADDRESS];
                        mem_in_data <= bus.req_wdata[gnt_idx*WIDTH +: WIDTH];
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    mem_wr_en <= 1'b0;
                    mem_rd_en <= 1'b0;
                    if (wr_q) begin
                        rsp_valid_q <= gnt_q_oh;
                        state_q     <= StResp;
                    end else begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    // Missing read data is a protocol error; return zeros rather than stale data.
                    rsp_rdata_q <= mem_valid_out ? mem_out_data : '0;
                    if (!mem_valid_out) err <= 1'b1;
                    rsp_valid_q <= gnt_q_oh;
                    state_q     <= StResp;
                end
                StResp: begin
                    rsp_valid_q <= '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomized scoreboard bench for rf_port_arbiter with an in-bench register file and a
// queue-based priority model; directed phases cover the listed corner cases.
module tb_rf_port_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int A = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_port_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ADDRESS(A)) bus ();

    logic         busy, err, mem_wr_en, mem_rd_en, mem_valid_out;
    logic [A-1:0] mem_address;
    logic [W-1:0] mem_in_data, mem_out_data;

    rf_port_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADDRESS(A)) u_dut (
        .clk          (clk),
        .rst          (rst_n),
        .bus          (bus.slave),
        .busy         (busy),
        .err          (err),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_address  (mem_address),
        .mem_in_data  (mem_in_data),
        .mem_out_data (mem_out_data),
        .mem_valid_out(mem_valid_out)
    );

    // Register file: 1-cycle registered read, reset by the same rst.
    logic [W-1:0] rf_mem [2**A];
    logic         rf_vout;
    logic         drop_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**A; i++) rf_mem[i] <= '0;
            mem_out_data <= '0;
            rf_vout      <= 1'b0;
        end else begin
            rf_vout <= mem_rd_en;
            if (mem_rd_en) mem_out_data <= rf_mem[mem_address];
            if (mem_wr_en) rf_mem[mem_address] <= mem_in_data;
        end
    end
    assign mem_valid_out = rf_vout & ~drop_valid;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Stimulus state per requester.
    logic [N-1:0] s_valid = '0;
    logic [N-1:0] s_write = '0;
    logic [A-1:0] s_addr [N];
    logic [W-1:0] s_data [N];

    task automatic apply();
        bus.req_valid = s_valid;
        bus.req_write = s_write;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*A +: A]  = s_addr[i];
            bus.req_wdata[i*W +: W] = s_data[i];
        end
    endtask

    // Reference model: priority list (front = highest), memory image, timing bookkeeping.
    typedef struct {
        int           id;
        bit           write;
        logic [W-1:0] data;
        bit           err;
        longint       due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           order[$];
    logic [W-1:0] ref_mem [2**A];
    logic [W-1:0] last_rdata;
    bit           ref_err;
    longint       next_free;
    longint       issue_cyc;
    bit           iss_w;
    logic [A-1:0] iss_a;
    logic [W-1:0] iss_d;
    int           acc_g;

    task automatic model_reset();
        order.delete();
        for (int i = 0; i < N; i++) order.push_back(i);
        for (int i = 0; i < 2**A; i++) ref_mem[i] = '0;
        last_rdata = '0;
        ref_err    = 1'b0;
        next_free  = 0;
        issue_cyc  = -1;
        sb.delete();
    endtask

    function automatic int pick();
`ifdef RF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (s_valid[i]) return i;
`else
        foreach (order[k]) if (s_valid[order[k]]) return order[k];
`endif
        return -1;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (cyc == issue_cyc) begin
            check("issue_wr_en", mem_wr_en, iss_w);
            check("issue_rd_en", mem_rd_en, !iss_w);
            check("issue_addr", mem_address, iss_a);
            check("issue_data", mem_in_data, iss_d);
        end else begin
            check("strobes_idle", {mem_wr_en, mem_rd_en}, 0);
        end
        check("busy", busy, cyc < next_free);
        acc_g = (cyc >= next_free) ? pick() : -1;
        check("req_ready", bus.req_ready, (acc_g >= 0) ? (64'd1 << acc_g) : 64'd0);
        if (acc_g >= 0) begin
            e.id    = acc_g;
            e.write = s_write[acc_g];
            if (e.write) begin
                ref_mem[s_addr[acc_g]] = s_data[acc_g];
            end else begin
                last_rdata = drop_valid ? '0 : ref_mem[s_addr[acc_g]];
                ref_err    = ref_err | drop_valid;
            end
            e.data    = last_rdata;
            e.err     = ref_err;
            e.due     = cyc + (e.write ? 2 : 3);
            sb.push_back(e);
            next_free = cyc + (e.write ? 3 : 4);
            issue_cyc = cyc + 1;
            iss_w     = e.write;
            iss_a     = s_addr[acc_g];
            iss_d     = s_data[acc_g];
            while (order[$] != acc_g) order.push_back(order.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int id, bit wr, int addr, logic [W-1:0] data);
        s_valid[id] = 1'b1;
        s_write[id] = wr;
        s_addr[id]  = A'(addr);
        s_data[id]  = data;
    endtask

    task automatic one_req(int id, bit wr, int addr, logic [W-1:0] data);
        int k;
        set_req(id, wr, addr, data);
        apply();
        k = 0;
        do begin
            tick();
            k++;
        end while (acc_g != id && k < 10);
        if (acc_g != id) check("grant_wait", acc_g, id);
        s_valid[id] = 1'b0;
        apply();
        repeat (4) tick();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ctrl"}, {bus.req_ready, bus.rsp_valid, busy, err, mem_wr_en, mem_rd_en,
                               mem_address}, 0);
        check({tag, "_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_wdata"}, mem_in_data, 0);
    endtask

    // Monitor: pops the scoreboard whenever a response is due and checks what the DUT shows.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check("rsp_valid", bus.rsp_valid, 64'd1 << mon_e.id);
                check("rsp_rdata", bus.rsp_rdata, mon_e.data);
                check("err", err, mon_e.err);
            end else if (bus.rsp_valid != '0) begin
                check("rsp_spurious", bus.rsp_valid, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            s_addr[i] = A'(i);
            s_data[i] = '0;
        end
        model_reset();
        // All four hold reads from reset; req_ready must stay low while reset is held.
        s_valid = '1;
        s_write = '0;
        apply();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (18) tick();
        s_valid = '0;
        apply();
        repeat (6) tick();

        // Write then read back through requester 0.
        one_req(0, 1'b1, 3, 32'hDEAD_BEEF);
        one_req(0, 1'b0, 3, 32'h0);

        // Fill addresses 0..3 with distinct data, then contending reads.
        for (int i = 0; i < N; i++) one_req(i, 1'b1, i, 32'hA5A5_0000 + 32'(i * 17));
        for (int i = 0; i < N; i++) set_req(i, 1'b0, i, '0);
        apply();
        repeat (20) tick();
        s_valid = '0;
        apply();
        repeat (6) tick();

        // Missing valid_out during the read wait: err sticks, data zero.
        drop_valid = 1'b1;
        one_req(1, 1'b0, 3, '0);
        drop_valid = 1'b0;
        one_req(2, 1'b0, 3, '0);

        // Requesters 1 and 3 contending continuously.
        set_req(1, 1'b0, 1, '0);
        set_req(3, 1'b0, 3, '0);
        apply();
        repeat (16) tick();
        s_valid = '0;
        apply();
        repeat (6) tick();

        // Reset during ISSUE of a write abandons it.
        set_req(0, 1'b1, 5, 32'h1234_5678);
        apply();
        tick();
        check("pre_reset_grant", acc_g, 0);
        s_valid = '0;
        apply();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        #2;
        rst_n = 1'b1;
        one_req(2, 1'b0, 5, '0);

        // Randomized traffic.
        for (int it = 0; it < 1500; it++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (i == acc_g) begin
                    if ($urandom_range(1, 0) == 1) begin
                        set_req(i, 1'($urandom_range(1, 0)), int'($urandom_range(2**A - 1, 0)),
                                $urandom);
                    end else begin
                        s_valid[i] = 1'b0;
                    end
                end else if (!s_valid[i]) begin
                    if ($urandom_range(99, 0) < 25) begin
                        set_req(i, 1'($urandom_range(1, 0)), int'($urandom_range(2**A - 1, 0)),
                                $urandom);
                    end
                end else if ($urandom_range(99, 0) < 3) begin
                    s_valid[i] = 1'b0;
                end
            end
            apply();
        end
        s_valid = '0;
        apply();
        repeat (6) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
Shares the single-port register file (WIDTH x 2^ADDRESS, 1-cycle registered read, async active-low reset) between NUM_REQ requesters. It arbitrates with round-robin, then drives one write or read access to the register file. It captures read data and returns a one-cycle response to the granted requester. It sits between the requester agents and the register file memory port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, data width; matches register file
ADDRESS, 4, address width; matches register file

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending
req_write  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDRESS  packed addresses, requester i at [i*ADDRESS +: ADDRESS]
req_wdata  in  NUM_REQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  WIDTH  read data; valid while rsp_valid set for a read
busy  out  1  state != IDLE
err  out  1  sticky protocol error flag
mem_wr_en  out  1  to register file wr_en
mem_rd_en  out  1  to register file rd_en
mem_address  out  ADDRESS  to register file address
mem_in_data  out  WIDTH  to register file in_data
mem_out_data  in  WIDTH  from register file out_data
mem_valid_out  in  1  from register file valid_out

Behaviour:
- Reset (rst low, any state): go to IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority. All registered outputs go to 0. req_ready is forced 0 while rst is low.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE: if any req_valid is set, grant g = first set bit searching from rr_ptr+1 upward with wrap-around. req_ready[g]=1 combinationally in the same cycle; a request is accepted when req_valid[g] and req_ready[g] are both high.
- On accept: latch g, req_write[g], addr and wdata. Set rr_ptr=g. Register mem_wr_en=req_write[g] and mem_rd_en=~req_write[g], with mem_address/mem_in_data = latched values. Go to ISSUE.
- ISSUE: memory strobes are high for exactly this one cycle and are cleared at its end. mem_wr_en and mem_rd_en are never both 1. Write -> RESP. Read -> RD_WAIT.
- RD_WAIT: sample mem_out_data into rsp_rdata at the end of the cycle. If mem_valid_out==0 here, set err=1 and load rsp_rdata=0. Go to RESP.
- RESP: rsp_valid[g]=1 for one cycle (registered). rsp_rdata holds its value until the next read response; writes leave it unchanged. Go to IDLE.
- Latency from accept cycle T: write response at T+2, read response at T+3. Next accept is possible in the cycle after RESP.
- req_ready is 0 in every state except IDLE. Requests arriving during a busy period wait; req_valid must be held until ready.
- A requester deasserting req_valid before it is accepted is legal; it is simply not granted.
- A held request from the just-served requester has lowest priority next round. This guarantees no starvation: at most NUM_REQ-1 grants go to others in between.
- err is cleared only by reset.
- Reset mid-access abandons the transaction with no response. The register file is reset by the same rst.

Optional Feature:
RF_ARB_FIXED_PRIO_EN: when defined, grant goes to the lowest-index requester with req_valid set, and rr_ptr is unused. When undefined, round-robin arbitration applies as above. Latency and the FSM are identical in both modes.

Test Plan:
- Reset, then req0 write addr 3 data 0xDEAD_BEEF -> req_ready[0] at T; at T+1 mem_wr_en=1, mem_address=3; rsp_valid=4'b0001 at T+2; busy high T+1..T+2.
- req0 read addr 3 after the previous write -> mem_rd_en at T+1; rsp_valid[0] at T+3 with rsp_rdata=0xDEAD_BEEF; err=0.
- All four requesters hold reads to addr 0..3 continuously from reset -> grant order 0,1,2,3,0; each requester gets rdata equal to its own address's contents.
- Force mem_valid_out=0 during RD_WAIT -> err=1 sticky, rsp_rdata=0, rsp_valid still pulses at T+3.
- Assert rst low during ISSUE of a write -> all outputs 0 asynchronously, no rsp_valid; after release, req2 is granted first if only req2 is valid.
- Build with RF_ARB_FIXED_PRIO_EN, req1 and req3 held valid -> req1 granted every round, req3 never granted while req1 stays valid.
